// File: rtl/direction_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | direction_control_if : sensor/command/timebase/motor bundle           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface direction_control_if;
  logic        sensor_l;
  logic        sensor_m;
  logic        sensor_r;
  logic [2:0]  input_action;
  logic [20:0] count_in;
  logic        count_reset;
  logic        motor_l_reset;
  logic        motor_l_direction;
  logic        motor_r_reset;
  logic        motor_r_direction;

  modport master (
    output sensor_l, sensor_m, sensor_r, input_action, count_in,
    input  count_reset, motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction
  );

  modport slave (
    input  sensor_l, sensor_m, sensor_r, input_action, count_in,
    output count_reset, motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction
  );
endinterface
`default_nettype wire

// File: rtl/direction_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | direction_control : per-period latch of action/sensors, motor drive   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module direction_control #(
  parameter int unsigned PERIOD = 2_000_000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  direction_control_if.slave bus
);

  localparam logic [20:0] C_LAST = 21'(PERIOD - 1);
  localparam logic [1:0]  C_FWD  = 2'd0;
  localparam logic [1:0]  C_REV  = 2'd1;
  localparam logic [1:0]  C_IDLE = 2'd2;

  typedef enum logic [0:0] {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_action;
  logic [2:0] r_sensors;
  logic       r_count_reset;
  logic       r_l_reset;
  logic       r_l_dir;
  logic       r_r_reset;
  logic       r_r_dir;

  // Returns {l_reset, l_dir, r_reset, r_dir}; right motor direction is mirrored.
  function automatic logic [3:0] f_decode(input logic [2:0] action, input logic [2:0] sensors);
    logic [1:0] l_cmd;
    logic [1:0] r_cmd;
    l_cmd = C_IDLE;
    r_cmd = C_IDLE;
    case (action)
      3'b000: begin
        case (sensors)
          3'b001, 3'b011: begin l_cmd = C_FWD;  r_cmd = C_IDLE; end
          3'b100, 3'b110: begin l_cmd = C_IDLE; r_cmd = C_FWD;  end
          default:        begin l_cmd = C_FWD;  r_cmd = C_FWD;  end
        endcase
      end
      3'b001:  begin l_cmd = C_REV;  r_cmd = C_FWD;  end
      3'b010:  begin l_cmd = C_FWD;  r_cmd = C_REV;  end
      3'b100:  begin l_cmd = C_REV;  r_cmd = C_REV;  end
      default: begin l_cmd = C_IDLE; r_cmd = C_IDLE; end
    endcase
    return {l_cmd == C_IDLE, l_cmd == C_FWD, r_cmd == C_IDLE, r_cmd == C_REV};
  endfunction

  logic [2:0] w_sensors;
  logic [3:0] w_next_cmd;
  logic [3:0] w_run_cmd;

  assign w_sensors  = {bus.sensor_l, bus.sensor_m, bus.sensor_r};
  assign w_next_cmd = f_decode(bus.input_action, w_sensors);
  assign w_run_cmd  = f_decode(r_action, r_sensors);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RESET;
      r_action      <= 3'b011;
      r_sensors     <= 3'b000;
      r_count_reset <= 1'b1;
      r_l_reset     <= 1'b1;
      r_l_dir       <= 1'b0;
      r_r_reset     <= 1'b1;
      r_r_dir       <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state       <= S_RUN;
          r_action      <= bus.input_action;
          r_sensors     <= w_sensors;
          r_count_reset <= 1'b0;
          {r_l_reset, r_l_dir, r_r_reset, r_r_dir} <= w_next_cmd;
        end
        default: begin
          if (bus.count_in >= C_LAST) begin
            // Directions hold through the restart cycle; only the resets assert.
            r_state       <= S_RESET;
            r_count_reset <= 1'b1;
            r_l_reset     <= 1'b1;
            r_r_reset     <= 1'b1;
          end else begin
            r_state       <= S_RUN;
            r_count_reset <= 1'b0;
            {r_l_reset, r_l_dir, r_r_reset, r_r_dir} <= w_run_cmd;
          end
        end
      endcase
    end
  end

  assign bus.count_reset       = r_count_reset;
  assign bus.motor_l_reset     = r_l_reset;
  assign bus.motor_l_direction = r_l_dir;
  assign bus.motor_r_reset     = r_r_reset;
  assign bus.motor_r_direction = r_r_dir;

endmodule
`default_nettype wire

// File: tb/tb_direction_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_direction_control : directed + random drive-period checks          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_direction_control;
  localparam int PERIOD = 4;
  localparam int SPAN   = PERIOD + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic freeze = 1'b0;
  always #5 clk = ~clk;

  direction_control_if bus();

  direction_control #(.PERIOD(PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Timebase: free-running counter cleared by count_reset, or pinned at 0 when frozen.
  always_ff @(posedge clk) begin
    if (bus.count_reset || freeze) bus.count_in <= '0;
    else                           bus.count_in <= bus.count_in + 21'd1;
  end

  int checks = 0;
  int errors = 0;

  int         n;
  logic       frozen = 1'b0;
  logic [3:0] cmd = 4'b1010;
  logic       last_ld = 1'b0;
  logic       last_rd = 1'b0;

  // Drive table as letters per wheel, then mapped to {l_reset,l_dir,r_reset,r_dir}.
  function automatic logic [3:0] ref_drive(input logic [2:0] a, input logic [2:0] s);
    byte l;
    byte r;
    if (a == 3'b100)      begin l = "B"; r = "B"; end
    else if (a == 3'b001) begin l = "B"; r = "F"; end
    else if (a == 3'b010) begin l = "F"; r = "B"; end
    else if (a == 3'b000) begin
      if (s == 3'b001 || s == 3'b011)      begin l = "F"; r = "S"; end
      else if (s == 3'b100 || s == 3'b110) begin l = "S"; r = "F"; end
      else                                 begin l = "F"; r = "F"; end
    end else begin l = "S"; r = "S"; end
    return {l == "S", l == "F", r == "S", r == "B"};
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] exp);
    chk({tag, ".count_reset"}, bus.count_reset,       exp[4]);
    chk({tag, ".l_reset"},     bus.motor_l_reset,     exp[3]);
    chk({tag, ".l_dir"},       bus.motor_l_direction, exp[2]);
    chk({tag, ".r_reset"},     bus.motor_r_reset,     exp[1]);
    chk({tag, ".r_dir"},       bus.motor_r_direction, exp[0]);
  endtask

  // Expected outputs for sample n: restart slot every SPAN clocks, latch on the slot after.
  task automatic check_model(input string tag);
    logic [4:0] exp;
    if (frozen) begin
      exp = {1'b0, cmd};
    end else if (n % SPAN == 0) begin
      exp = {1'b1, 1'b1, last_ld, 1'b1, last_rd};
    end else begin
      if (n % SPAN == 1)
        cmd = ref_drive(bus.input_action, {bus.sensor_l, bus.sensor_m, bus.sensor_r});
      exp = {1'b0, cmd};
    end
    last_ld = exp[2];
    last_rd = exp[0];
    chk_all(tag, exp);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    n++;
    check_model(tag);
  endtask

  task automatic set_in(input logic [2:0] a, input logic [2:0] s);
    bus.input_action = a;
    {bus.sensor_l, bus.sensor_m, bus.sensor_r} = s;
  endtask

  logic [2:0] d_act  [10] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b101, 3'b011};
  logic [2:0] d_sens [10] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b111, 3'b010, 3'b000, 3'b000};

  initial begin
    set_in(3'b011, 3'b000);
    n = 0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all("in_reset", 5'b1_1_0_1_0);
    end
    reset = 1'b1;
    #1;
    check_model("release");

    for (int i = 0; i < 10; i++) begin
      set_in(d_act[i], d_sens[i]);
      for (int k = 0; k < SPAN + 1; k++) cycle("directed");
    end

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0)
        set_in(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      cycle("random");
    end

    // Timebase stuck at 0: command latched on this period must persist regardless of inputs.
    set_in(3'b001, 3'b000);
    while (n % SPAN != 1) cycle("pre_freeze");
    freeze = 1'b1;
    frozen = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_in(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      cycle("frozen");
    end

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 5'b1_1_0_1_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
